// File: rtl/i2c_led_array_pkg.sv
// Shared constants for the I2C-fed WS2812 LED controller: serialiser state
// encodings and the brightness register address.
package i2c_led_array_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_LOW  = 3'd3;
    localparam logic [2:0] ST_RST  = 3'd4;

    localparam logic [7:0] REG_BRIGHT = 8'hFF;

endpackage

// File: rtl/ws2812_tx.sv
// WS2812 serialiser: fetches bytes on request, sends them MSB first with
// per-bit high/low timing, then holds the line low for the latch period.
module ws2812_tx
    import i2c_led_array_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 9,
    parameter int unsigned T0H_CYC   = 4,
    parameter int unsigned T1H_CYC   = 8,
    parameter int unsigned TBIT_CYC  = 12,
    parameter int unsigned TRST_CYC  = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_req,
    output logic       frame_done,
    output logic       led_o,
    output logic       busy
);

    localparam logic [15:0] T0H  = 16'(T0H_CYC);
    localparam logic [15:0] T1H  = 16'(T1H_CYC);
    localparam logic [15:0] LOW0 = 16'(TBIT_CYC - T0H_CYC);
    localparam logic [15:0] LOW1 = 16'(TBIT_CYC - T1H_CYC);
    localparam logic [15:0] TRST = 16'(TRST_CYC);

    logic [2:0]  state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        val_q, val_d;
    logic [7:0]  cur;
    logic        last;

    assign last  = (bit_q == 3'd7) && (byte_cnt_q == 8'(NUM_BYTES - 1));
    assign led_o = (state_q == ST_HIGH);
    assign busy  = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        byte_cnt_d = byte_cnt_q;
        sh_d       = sh_q;
        val_d      = val_q;
        byte_req   = 1'b0;
        frame_done = 1'b0;
        cur        = (bit_q == 3'd0) ? byte_in : sh_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_valid) begin
                    state_d    = ST_LOAD;
                    bit_d      = 3'd0;
                    byte_cnt_d = 8'd0;
                end
            end
            ST_LOAD: begin
                byte_req = (bit_q == 3'd0);
                val_d    = cur[7];
                sh_d     = {cur[6:0], 1'b0};
                cyc_d    = cur[7] ? T1H - 16'd1 : T0H - 16'd1;
                state_d  = ST_HIGH;
            end
            ST_HIGH: begin
                if (cyc_q == 16'd0) begin
                    state_d = ST_LOW;
                    // LOAD of the next bit supplies one low cycle, except after the last bit
                    cyc_d   = (val_q ? LOW1 : LOW0) - (last ? 16'd1 : 16'd2);
                end else begin
                    cyc_d = cyc_q - 16'd1;
                end
            end
            ST_LOW: begin
                if (cyc_q != 16'd0) begin
                    cyc_d = cyc_q - 16'd1;
                end else if (last) begin
                    state_d = ST_RST;
                    cyc_d   = TRST - 16'd1;
                end else begin
                    state_d = ST_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            ST_RST: begin
                if (cyc_q == 16'd0) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end else begin
                    cyc_d = cyc_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 16'd0;
            bit_q      <= 3'd0;
            byte_cnt_q <= 8'd0;
            sh_q       <= 8'd0;
            val_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            byte_cnt_q <= byte_cnt_d;
            sh_q       <= sh_d;
            val_q      <= val_d;
        end
    end

endmodule

// File: rtl/i2c_led_array.sv
// Register-mapped WS2812 chain controller fed by an I2C byte stream, with
// shadow/active frame buffers. Optional global dimmer: define GLOBAL_DIM_EN.
module i2c_led_array
    import i2c_led_array_pkg::*;
#(
    parameter int unsigned LED_CNT  = 3,
    parameter int unsigned COLORS   = 3,
    parameter int unsigned T0H_CYC  = 4,
    parameter int unsigned T1H_CYC  = 8,
    parameter int unsigned TBIT_CYC = 12,
    parameter int unsigned TRST_CYC = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_start,
    input  logic       rx_stop,
    output logic       led_o,
    output logic       busy_o,
    output logic       pending_o
);

    localparam int unsigned NUM_BYTES = LED_CNT * COLORS;
    localparam logic [7:0]  LAST_PTR  = 8'(NUM_BYTES - 1);

    logic [7:0] shadow_q [NUM_BYTES];
    logic [7:0] shadow_d [NUM_BYTES];
    logic [7:0] active_q [NUM_BYTES];
    logic [7:0] ptr_q, idx_q;
    logic       expect_ptr_q, dirty_q, pending_q;
    logic       wr_en, commit, start;
    logic       tx_busy, byte_req, frame_done;
    logic [7:0] byte_raw, byte_tx;

    assign wr_en     = rx_valid && !expect_ptr_q && (ptr_q < 8'(NUM_BYTES));
    // A byte arriving with STOP is written first, so it counts toward the commit
    assign commit    = rx_stop && (dirty_q || wr_en);
    assign start     = !tx_busy && (commit || pending_q);
    assign busy_o    = tx_busy;
    assign pending_o = pending_q;

    always_comb begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            shadow_d[i] = (wr_en && ptr_q == 8'(i)) ? rx_data : shadow_q[i];
        end
    end

    always_comb begin
        byte_raw = 8'd0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == 8'(i)) byte_raw = active_q[i];
        end
    end

`ifdef GLOBAL_DIM_EN
    logic [7:0]  bright_q;
    logic [15:0] prod;
    logic        bright_wr;

    assign bright_wr = rx_valid && !expect_ptr_q && (ptr_q == REG_BRIGHT);
    assign prod      = 16'(byte_raw) * (16'(bright_q) + 16'd1);
    assign byte_tx   = 8'(prod >> 8);

    always_ff @(posedge clk) begin
        if (reset) begin
            bright_q <= 8'hFF;
        end else if (bright_wr) begin
            bright_q <= rx_data;
        end
    end
`else
    assign byte_tx = byte_raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                shadow_q[i] <= 8'd0;
                active_q[i] <= 8'd0;
            end
            ptr_q        <= 8'd0;
            idx_q        <= 8'd0;
            expect_ptr_q <= 1'b0;
            dirty_q      <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (rx_valid && expect_ptr_q) begin
                ptr_q        <= rx_data;
                expect_ptr_q <= 1'b0;
            end else if (wr_en) begin
                ptr_q <= (ptr_q == LAST_PTR) ? 8'd0 : ptr_q + 8'd1;
            end
            if (rx_start) expect_ptr_q <= 1'b1;

            if (commit) begin
                dirty_q <= 1'b0;
            end else if (wr_en) begin
                dirty_q <= 1'b1;
            end

            // Back-to-back commits collapse into one copy of the latest shadow
            if (start) begin
                active_q  <= shadow_d;
                pending_q <= 1'b0;
            end else if (commit) begin
                pending_q <= 1'b1;
            end

            if (start || frame_done) begin
                idx_q <= 8'd0;
            end else if (byte_req) begin
                idx_q <= idx_q + 8'd1;
            end
        end
    end

    ws2812_tx #(
        .NUM_BYTES(NUM_BYTES),
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC),
        .TRST_CYC (TRST_CYC)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_tx),
        .byte_valid(start),
        .byte_req  (byte_req),
        .frame_done(frame_done),
        .led_o     (led_o),
        .busy      (tx_busy)
    );

endmodule

// File: tb/tb_i2c_led_array.sv
// Directed bench for i2c_led_array: decodes led_o pulse widths back into bytes.
module tb_i2c_led_array;

    localparam int NB = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid, rx_start, rx_stop;
    logic       led_o, busy_o, pending_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] want [NB];
    int         waited;
    int         hits;

    always #5 clk = ~clk;

    i2c_led_array #(
        .LED_CNT (3),
        .COLORS  (3),
        .T0H_CYC (4),
        .T1H_CYC (8),
        .TBIT_CYC(12),
        .TRST_CYC(600)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_start (rx_start),
        .rx_stop  (rx_stop),
        .led_o    (led_o),
        .busy_o   (busy_o),
        .pending_o(pending_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic strobe(input logic s, input logic v, input logic [7:0] d, input logic p);
        @(negedge clk);
        rx_start = s;
        rx_valid = v;
        rx_data  = d;
        rx_stop  = p;
        @(negedge clk);
        rx_start = 1'b0;
        rx_valid = 1'b0;
        rx_stop  = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] w [NB], input int max_wait,
                                output int wcnt);
        logic [7:0] got;
        int hi, lo, bad;
        wcnt = 0;
        while (led_o !== 1'b1 && wcnt < max_wait) begin
            @(negedge clk);
            wcnt++;
        end
        check({tag, " start"}, {31'b0, led_o}, 32'd1);
        if (led_o !== 1'b1) return;
        bad = 0;
        for (int b = 0; b < NB; b++) begin
            got = 8'd0;
            for (int k = 0; k < 8; k++) begin
                hi = 0;
                while (led_o === 1'b1 && hi < 50) begin
                    hi++;
                    @(negedge clk);
                end
                lo = 0;
                if (b == NB - 1 && k == 7) begin
                    while (busy_o === 1'b1 && lo < 2000) begin
                        lo++;
                        @(negedge clk);
                    end
                    check({tag, " latch"}, lo, (12 - hi) + 600);
                end else begin
                    while (led_o === 1'b0 && lo < 50) begin
                        lo++;
                        @(negedge clk);
                    end
                    if (hi + lo != 12) bad++;
                end
                if (hi != 4 && hi != 8) bad++;
                got = {got[6:0], (hi == 8)};
            end
            check($sformatf("%s byte%0d", tag, b), got, w[b]);
        end
        check({tag, " timing"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        rx_start = 1'b0;
        rx_stop  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst led", {31'b0, led_o}, 0);
        check("rst busy", {31'b0, busy_o}, 0);
        check("rst pending", {31'b0, pending_o}, 0);
        reset = 1'b0;

        // 1: full frame 01..09, latency and latch
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'h00, 0);
        for (int i = 1; i <= 9; i++) strobe(0, 1, 8'(i), 0);
        strobe(0, 0, 8'h00, 1);
        check("t1 load led", {31'b0, led_o}, 0);
        check("t1 load busy", {31'b0, busy_o}, 1);
        check("t1 pending", {31'b0, pending_o}, 0);
        @(negedge clk);
        check("t1 rise", {31'b0, led_o}, 1);
        for (int i = 0; i < NB; i++) want[i] = 8'(i + 1);
        expect_frame("t1", want, 0, waited);
        check("t1 idle", {31'b0, busy_o}, 0);

        // 2: pointer wrap
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'h08, 0);
        strobe(0, 1, 8'hAA, 0);
        strobe(0, 1, 8'hBB, 0);
        strobe(0, 0, 8'h00, 1);
        want[0] = 8'hBB;
        want[8] = 8'hAA;
        expect_frame("t2", want, 5, waited);
        check("t2 latency", waited, 1);

        // 3: commits during a running frame merge into one extra frame
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'h00, 0);
        strobe(0, 1, 8'h11, 0);
        strobe(0, 0, 8'h00, 1);
        want[0] = 8'h11;
        fork
            expect_frame("t3a", want, 5, waited);
            begin
                repeat (20) @(negedge clk);
                strobe(1, 0, 8'h00, 0);
                strobe(0, 1, 8'h01, 0);
                strobe(0, 1, 8'h22, 0);
                strobe(0, 0, 8'h00, 1);
                check("t3 pending1", {31'b0, pending_o}, 1);
                strobe(1, 0, 8'h00, 0);
                strobe(0, 1, 8'h02, 0);
                strobe(0, 1, 8'h33, 0);
                strobe(0, 0, 8'h00, 1);
                check("t3 pending2", {31'b0, pending_o}, 1);
            end
        join
        check("t3 pending held", {31'b0, pending_o}, 1);
        want[1] = 8'h22;
        want[2] = 8'h33;
        expect_frame("t3b", want, 5, waited);
        check("t3 back2back", waited, 2);
        hits = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || led_o !== 1'b0) hits++;
        end
        check("t3 no third frame", hits, 0);

        // 4: out-of-range pointer drops data, no commit
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'h20, 0);
        strobe(0, 1, 8'h55, 0);
        strobe(0, 0, 8'h00, 1);
        hits = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || led_o !== 1'b0) hits++;
        end
        check("t4 no frame", hits, 0);
        check("t4 pending", {31'b0, pending_o}, 0);
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'h03, 0);
        strobe(0, 1, 8'h66, 0);
        strobe(0, 0, 8'h00, 1);
        want[3] = 8'h66;
        expect_frame("t4", want, 5, waited);

        // 5: reset during HIGH aborts the frame and clears buffers
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'h00, 0);
        strobe(0, 1, 8'h44, 0);
        strobe(0, 0, 8'h00, 1);
        waited = 0;
        while (led_o !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        check("t5 mid high", {31'b0, led_o}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5 rst led", {31'b0, led_o}, 0);
        check("t5 rst busy", {31'b0, busy_o}, 0);
        reset = 1'b0;
        hits = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || led_o !== 1'b0) hits++;
        end
        check("t5 quiet", hits, 0);
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'h00, 0);
        strobe(0, 1, 8'h5A, 1);
        for (int i = 0; i < NB; i++) want[i] = 8'h00;
        want[0] = 8'h5A;
        expect_frame("t5", want, 5, waited);
        check("t5 latency", waited, 1);

        // 6: brightness register at pointer 0xFF
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'hFF, 0);
        strobe(0, 1, 8'h7F, 0);
        strobe(1, 0, 8'h00, 0);
        strobe(0, 1, 8'h00, 0);
        strobe(0, 1, 8'hFF, 0);
        strobe(0, 0, 8'h00, 1);
`ifdef GLOBAL_DIM_EN
        want[0] = 8'h7F;
`else
        want[0] = 8'hFF;
`endif
        expect_frame("t6", want, 5, waited);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
